// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcodes, flag bit positions, the reset flag value
// and the FSM state type.
package seq_alu_pkg;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;
  localparam logic [7:0] OP_INC  = 8'h05;
  localparam logic [7:0] OP_DEC  = 8'h06;
  localparam logic [7:0] OP_MOD  = 8'h07;
  localparam logic [7:0] OP_SHL  = 8'h08;
  localparam logic [7:0] OP_SHR  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_NAND = 8'h0B;
  localparam logic [7:0] OP_NOR  = 8'h0D;
  localparam logic [7:0] OP_NOT  = 8'h0E;
  localparam logic [7:0] OP_OR   = 8'h0F;
  localparam logic [7:0] OP_XNOR = 8'h10;
  localparam logic [7:0] OP_XOR  = 8'h11;
  localparam logic [7:0] OP_ROL  = 8'h12;
  localparam logic [7:0] OP_ROR  = 8'h13;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_SIGN   = 2;
  localparam int FLAG_PARITY = 3;
  localparam int FLAG_INT    = 4;
  localparam int FLAG_DIR    = 5;
  localparam int FLAG_OVF    = 6;

  // Flags of an all-zero result: zero and even parity set.
  localparam logic [6:0] FLAGS_RESET = 7'b0001001;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus of seq_alu; the ALU side uses the slave modport.
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [7:0]       ALU_sel;
  logic             out_valid;
  logic [WIDTH-1:0] operation_result;
  logic [6:0]       Flags;

  modport master (
    output in_valid, operand1, operand2, ALU_sel,
    input  in_ready, out_valid, operation_result, Flags
  );

  modport slave (
    input  in_valid, operand1, operand2, ALU_sel,
    output in_ready, out_valid, operation_result, Flags
  );
endinterface

// File: rtl/seq_alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle. quotient and
// remainder show the final values combinationally in the cycle done is high.
module seq_alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH:0]   shifted;
  logic             fits;

  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    fits      = (shifted >= {1'b0, den_q});
    quotient  = {quo_q[WIDTH-2:0], fits};
    remainder = fits ? WIDTH'(shifted - {1'b0, den_q}) : shifted[WIDTH-1:0];
    done      = busy_q && (cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      den_q  <= divisor;
    end else if (busy_q) begin
      quo_q  <= quotient;
      rem_q  <= remainder;
      cnt_q  <= done ? '0 : cnt_q + 1'b1;
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, WIDTH-cycle shift-add multiply and, when the
// SEQ_ALU_DIV_EN macro is defined, a WIDTH-cycle restoring divide/modulo.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   result_q;
  logic [6:0]         flags_q;
  logic               out_valid_q;
  logic               accept;

  logic [WIDTH:0]     alu_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_o, alu_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               fin, c_d, o_d, d_d;
  logic [WIDTH-1:0]   res_d;
  logic [6:0]         flags_d;

`ifdef SEQ_ALU_DIV_EN
  logic [7:0]       op_q;
  logic             is_div, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign is_div    = (bus.ALU_sel == OP_DIV) || (bus.ALU_sel == OP_MOD);
  assign div_start = accept && is_div && (bus.operand2 != '0);

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (bus.operand1),
    .divisor  (bus.operand2),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );
`endif

  assign bus.in_ready         = (state_q == IDLE) && !rst;
  assign bus.out_valid        = out_valid_q;
  assign bus.operation_result = result_q;
  assign bus.Flags            = flags_q;
  assign accept               = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_o    = 1'b0;
    alu_d    = 1'b0;
    case (bus.ALU_sel)
      OP_ADD: begin
        alu_wide = {1'b0, bus.operand1} + {1'b0, bus.operand2};
        alu_res  = alu_wide[M:0];
        alu_c    = alu_wide[WIDTH];
        alu_o    = (bus.operand1[M] == bus.operand2[M]) && (alu_res[M] != bus.operand1[M]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, bus.operand1} - {1'b0, bus.operand2};
        alu_res  = alu_wide[M:0];
        alu_c    = alu_wide[WIDTH];
        alu_o    = (bus.operand1[M] != bus.operand2[M]) && (alu_res[M] != bus.operand1[M]);
      end
      OP_INC: begin
        alu_wide = {1'b0, bus.operand1} + ONE_W;
        alu_res  = alu_wide[M:0];
        alu_c    = alu_wide[WIDTH];
        alu_o    = (bus.operand1 == {1'b0, {M{1'b1}}});
      end
      OP_DEC: begin
        alu_wide = {1'b0, bus.operand1} - ONE_W;
        alu_res  = alu_wide[M:0];
        alu_c    = alu_wide[WIDTH];
        alu_o    = (bus.operand1 == {1'b1, {M{1'b0}}});
      end
      OP_SHL: begin
        alu_res = {bus.operand1[M-1:0], 1'b0};
        alu_c   = bus.operand1[M];
        alu_o   = bus.operand1[M] ^ bus.operand1[M-1];
        alu_d   = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.operand1[M:1]};
        alu_c   = bus.operand1[0];
      end
      OP_ROL: begin
        alu_res = {bus.operand1[M-1:0], bus.operand1[M]};
        alu_c   = bus.operand1[M];
      end
      OP_ROR: begin
        alu_res = {bus.operand1[0], bus.operand1[M:1]};
        alu_c   = bus.operand1[0];
      end
      OP_AND:  alu_res = bus.operand1 & bus.operand2;
      OP_NAND: alu_res = ~(bus.operand1 & bus.operand2);
      OP_NOR:  alu_res = ~(bus.operand1 | bus.operand2);
      OP_NOT:  alu_res = ~bus.operand1;
      OP_OR:   alu_res = bus.operand1 | bus.operand2;
      OP_XNOR: alu_res = ~(bus.operand1 ^ bus.operand2);
      OP_XOR:  alu_res = bus.operand1 ^ bus.operand2;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: the multiplier sits in the low half and shifts out as the
  // partial product grows into the high half.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    res_d   = '0;
    c_d     = 1'b0;
    o_d     = 1'b0;
    d_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.ALU_sel == OP_MUL) begin
            state_d = MUL;
`ifdef SEQ_ALU_DIV_EN
          end else if (is_div && (bus.operand2 != '0)) begin
            state_d = DIV;
          end else if (is_div) begin
            fin   = 1'b1;
            res_d = (bus.ALU_sel == OP_DIV) ? '1 : bus.operand1;
            o_d   = 1'b1;
`endif
          end else begin
            fin   = 1'b1;
            res_d = alu_res;
            c_d   = alu_c;
            o_d   = alu_o;
            d_d   = alu_d;
          end
        end
      end
      MUL: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          fin     = 1'b1;
          res_d   = mul_next[WIDTH-1:0];
          c_d     = |mul_next[2*WIDTH-1:WIDTH];
          o_d     = |mul_next[2*WIDTH-1:WIDTH];
        end
      end
      DIV: begin
`ifdef SEQ_ALU_DIV_EN
        if (div_done) begin
          state_d = IDLE;
          fin     = 1'b1;
          res_d   = (op_q == OP_MOD) ? div_rem : div_quo;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    flags_d              = '0;
    flags_d[FLAG_ZERO]   = (res_d == '0);
    flags_d[FLAG_CARRY]  = c_d;
    flags_d[FLAG_SIGN]   = res_d[M];
    flags_d[FLAG_PARITY] = ~^res_d;
    flags_d[FLAG_INT]    = 1'b0;
    flags_d[FLAG_DIR]    = d_d;
    flags_d[FLAG_OVF]    = o_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_RESET;
`ifdef SEQ_ALU_DIV_EN
      op_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= fin;
      if (fin) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
      if (accept) begin
        prod_q  <= {{WIDTH{1'b0}}, bus.operand2};
        mcand_q <= bus.operand1;
        cnt_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
        op_q    <= bus.ALU_sel;
`endif
      end else if (state_q == MUL) begin
        prod_q <= mul_next;
        cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end
endmodule
